// File: rtl/sharpening_pkg.sv
// Shared widths, types and saturation limits for the 3x3 sharpening convolution.
package sharpening_pkg;
  localparam int PIX_W  = 9;
  localparam int COEF_W = 8;
  localparam int OUT_W  = 17;
  localparam int K      = 3;
  localparam int PROD_W = PIX_W + 1 + COEF_W;
  localparam int ACC_W  = PROD_W + 4;

  typedef logic        [PIX_W-1:0]  pixel_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [OUT_W-1:0]  result_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef pixel_t window_t [0:K-1][0:K-1];
  typedef coef_t  kernel_t [0:K-1][0:K-1];

  localparam result_t SAT_MAX = 17'sh0FFFF;
  localparam result_t SAT_MIN = 17'sh10000;
  localparam acc_t    ACC_MAX = 22'sd65535;
  localparam acc_t    ACC_MIN = -22'sd65536;
endpackage

// File: rtl/sharpening_sat.sv
// Combinational clipper: 22-bit signed sum down to the 17-bit output range, with clip flag.
module sharpening_sat
  import sharpening_pkg::*;
(
  input  acc_t    sum,
  output result_t res,
  output logic    sat
);
  always_comb begin
    res = sum[OUT_W-1:0];
    sat = 1'b0;
    if (sum > ACC_MAX) begin
      res = SAT_MAX;
      sat = 1'b1;
    end else if (sum < ACC_MIN) begin
      res = SAT_MIN;
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/sharpening.sv
// 3x3 sharpening convolution: input register, product register, then adder tree and
// saturation into the output register. One result per clock.
module sharpening
  import sharpening_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  pixel_t  img [0:K-1][0:K-1],
  input  coef_t   fil [0:K-1][0:K-1],
  output result_t out,
  output logic    out_valid,
  output logic    out_sat
);
  window_t    img_q;
  kernel_t    fil_q;
  prod_t      prod_d [0:K-1][0:K-1];
  prod_t      prod_q [0:K-1][0:K-1];
  acc_t       sum;
  result_t    sat_res;
  logic       sat_flag;
  logic [2:0] valid_q;

  // Pixel gets a zero sign bit so -128 coefficients multiply exactly in 18 bits.
  always_comb begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        prod_d[r][c] = prod_t'($signed({1'b0, img_q[r][c]})) * prod_t'(fil_q[r][c]);
  end

  always_comb begin
    sum = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        sum = sum + acc_t'(prod_q[r][c]);
  end

  sharpening_sat u_sat (
    .sum (sum),
    .res (sat_res),
    .sat (sat_flag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) begin
          img_q[r][c]  <= '0;
          fil_q[r][c]  <= '0;
          prod_q[r][c] <= '0;
        end
      out     <= '0;
      out_sat <= 1'b0;
      valid_q <= '0;
    end else begin
      img_q   <= img;
      fil_q   <= fil;
      prod_q  <= prod_d;
      out     <= sat_res;
      out_sat <= sat_flag;
      valid_q <= {valid_q[1:0], 1'b1};
    end
  end

  assign out_valid = valid_q[2];
endmodule

// File: tb/tb_sharpening.sv
// Self-checking bench for sharpening: directed vector table, streaming against a
// plain-arithmetic model, and reset/refill sequences.
module tb_sharpening;
  import sharpening_pkg::*;

  typedef int imat_t [0:2][0:2];
  typedef struct {
    string name;
    imat_t im;
    imat_t fl;
    int    exp_out;
    bit    exp_sat;
  } vec_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  window_t img;
  kernel_t fil;
  result_t out;
  logic    out_valid;
  logic    out_sat;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_q[$];
  bit   sat_q[$];
  vec_t vt[$];

  always #5 clk = ~clk;

  sharpening dut (
    .clk       (clk),
    .rst       (rst),
    .img       (img),
    .fil       (fil),
    .out       (out),
    .out_valid (out_valid),
    .out_sat   (out_sat)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer dot product, then clamp to the 17-bit signed range.
  function automatic int model(input imat_t im, input imat_t fl, output bit sat);
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += im[r][c] * fl[r][c];
    sat = 1'b0;
    if (s > 65535) begin
      sat = 1'b1;
      return 65535;
    end
    if (s < -65536) begin
      sat = 1'b1;
      return -65536;
    end
    return s;
  endfunction

  function automatic imat_t center(input int v);
    imat_t m = '{default: 0};
    m[1][1] = v;
    return m;
  endfunction

  task automatic drive(input imat_t im, input imat_t fl);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        img[r][c] = pixel_t'(im[r][c]);
        fil[r][c] = coef_t'(fl[r][c]);
      end
  endtask

  task automatic add_vec(input string name, input imat_t im, input imat_t fl,
                         input int exp_out, input bit exp_sat);
    vec_t v;
    v.name = name; v.im = im; v.fl = fl; v.exp_out = exp_out; v.exp_sat = exp_sat;
    vt.push_back(v);
  endtask

  // Called at a negedge; checks the result due now, drives a new window, ends at next negedge.
  task automatic stream_step(input imat_t im, input imat_t fl);
    int e;
    bit s;
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      s = sat_q.pop_front();
      chk("stream_out", int'(out), e);
      chk("stream_sat", int'(out_sat), int'(s));
      chk("stream_valid", int'(out_valid), 1);
    end
    drive(im, fl);
    e = model(im, fl, s);
    exp_q.push_back(e);
    sat_q.push_back(s);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    imat_t z   = '{default: 0};
    imat_t im, fl;
    imat_t f511 = '{default: 511};

    add_vec("sharpen", '{'{2,0,0},'{5,255,0},'{1,2,4}}, '{'{0,-1,0},'{-1,5,-1},'{0,-1,0}}, 1268, 1'b0);
    add_vec("ident_pos", center(511), center(1), 511, 1'b0);
    add_vec("ident_neg", center(511), center(-1), -511, 1'b0);
    add_vec("sat_pos", f511, '{default: 127}, 65535, 1'b1);
    add_vec("sat_neg", f511, '{default: -128}, -65536, 1'b1);
    add_vec("fit_max", '{'{511,127,0},'{0,511,0},'{0,0,0}}, '{'{1,1,0},'{0,127,0},'{0,0,0}}, 65535, 1'b0);
    add_vec("over_max", '{'{511,128,0},'{0,511,0},'{0,0,0}}, '{'{1,1,0},'{0,127,0},'{0,0,0}}, 65535, 1'b1);
    add_vec("fit_min", '{'{1,0,0},'{0,511,0},'{0,0,0}}, '{'{-128,0,0},'{0,-128,0},'{0,0,0}}, -65536, 1'b0);
    add_vec("under_min", '{'{1,1,0},'{0,511,0},'{0,0,0}}, '{'{-128,-1,0},'{0,-128,0},'{0,0,0}}, -65536, 1'b1);
    add_vec("zero_coef", f511, z, 0, 1'b0);
    add_vec("zero_pix", z, '{default: -128}, 0, 1'b0);
    add_vec("neg128", center(511), center(-128), -65408, 1'b0);

    drive(z, z);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out", int'(out), 0);
    chk("rst_sat", int'(out_sat), 0);
    chk("rst_valid", int'(out_valid), 0);
    rst = 1'b0;
    @(negedge clk); chk("valid_e1", int'(out_valid), 0);
    @(negedge clk); chk("valid_e2", int'(out_valid), 0);
    @(negedge clk); chk("valid_e3", int'(out_valid), 1);

    foreach (vt[i]) begin
      drive(vt[i].im, vt[i].fl);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk({vt[i].name, "_out"}, int'(out), vt[i].exp_out);
      chk({vt[i].name, "_sat"}, int'(out_sat), int'(vt[i].exp_sat));
    end

    // Back-to-back identity windows: results must appear on consecutive cycles.
    exp_q.delete(); sat_q.delete();
    for (int i = 0; i < 13; i++) stream_step(center(i < 10 ? i : 0), center(1));

    exp_q.delete(); sat_q.delete();
    for (int n = 0; n < 300; n++) begin
      bit big = ($urandom_range(0, 3) == 0);
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          im[r][c] = big ? int'($urandom_range(400, 511)) : int'($urandom_range(0, 511));
          fl[r][c] = big ? ($urandom_range(0, 1) == 1 ? int'($urandom_range(100, 127))
                                                     : -int'($urandom_range(100, 128)))
                         : int'($urandom_range(0, 255)) - 128;
        end
      stream_step(im, fl);
    end

    // Mid-stream reset: pipeline flushes, then refills with no early valid.
    rst = 1'b1;
    exp_q.delete(); sat_q.delete();
    @(negedge clk);
    chk("mid_rst_out", int'(out), 0);
    chk("mid_rst_sat", int'(out_sat), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(center(77), center(1));
    @(negedge clk);
    chk("refill1_valid", int'(out_valid), 0);
    chk("refill1_out", int'(out), 0);
    @(negedge clk);
    chk("refill2_valid", int'(out_valid), 0);
    chk("refill2_out", int'(out), 0);
    @(negedge clk);
    chk("refill3_valid", int'(out_valid), 1);
    chk("refill3_out", int'(out), 77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
